// File: rtl/digital_monitor_sequencer_if.sv
// Bus from the monitor sequencer to the digital monitor mux.
// The master drives enable/select/channel; the mux side takes the slave view.
interface digital_monitor_sequencer_if #(
  parameter int unsigned CHAN_WIDTH = 6
);
  logic                  digital_monitor_enable;
  logic [3:0]            digital_monitor_select;
  logic [CHAN_WIDTH-1:0] digital_monitor_chan;

  modport master (
    output digital_monitor_enable,
    output digital_monitor_select,
    output digital_monitor_chan
  );

  modport slave (
    input digital_monitor_enable,
    input digital_monitor_select,
    input digital_monitor_chan
  );
endinterface

// File: rtl/digital_monitor_sequencer.sv
// Drives the digital monitor mux: static pass-through of config values, or an
// automatic scan over a masked channel set with programmable dwell and blanking gap.
module digital_monitor_sequencer #(
  parameter int unsigned NUM_CHANNELS = 64,
  parameter int unsigned CHAN_WIDTH   = 6,
  parameter int unsigned DWELL_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    static_enable,
  input  logic [3:0]              static_select,
  input  logic [CHAN_WIDTH-1:0]   static_chan,
  input  logic                    scan_start,
  input  logic                    scan_stop,
  input  logic                    scan_continuous,
  input  logic [3:0]              scan_select,
  input  logic [NUM_CHANNELS-1:0] scan_chan_mask,
  input  logic [DWELL_WIDTH-1:0]  scan_dwell,
  input  logic [3:0]              scan_gap,
  digital_monitor_sequencer_if.master mon,
  output logic                    scan_active,
  output logic                    scan_done,
  output logic                    scan_wrap,
  output logic                    scan_error
);

  typedef enum logic [1:0] {IDLE, DWELL, GAP} state_t;

  state_t                  state_q;
  logic                    enable_q;
  logic [3:0]              select_q;
  logic [CHAN_WIDTH-1:0]   chan_q;

  logic [NUM_CHANNELS-1:0] mask_q;
  logic                    cont_q;
  logic [3:0]              sel_q;
  logic [DWELL_WIDTH-1:0]  dwell_q;
  logic [3:0]              gap_q;
  logic [DWELL_WIDTH-1:0]  dwell_cnt;
  logic [3:0]              gap_cnt;

  logic [CHAN_WIDTH-1:0]   first_start;
  logic [CHAN_WIDTH-1:0]   first_q;
  logic                    next_found;
  logic [CHAN_WIDTH-1:0]   next_chan;
  logic                    has_next;
  logic                    step_adv;
  logic [DWELL_WIDTH-1:0]  dwell_load_in;
  logic [DWELL_WIDTH-1:0]  dwell_load_q;

  assign mon.digital_monitor_enable = enable_q;
  assign mon.digital_monitor_select = select_q;
  assign mon.digital_monitor_chan   = chan_q;

  // Lowest set bit of the incoming mask (scan start) and of the latched mask (wrap).
  always_comb begin
    logic found_in;
    logic found_q;
    first_start = '0;
    first_q     = '0;
    found_in    = 1'b0;
    found_q     = 1'b0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (!found_in && scan_chan_mask[i]) begin
        found_in    = 1'b1;
        first_start = CHAN_WIDTH'(i);
      end
      if (!found_q && mask_q[i]) begin
        found_q = 1'b1;
        first_q = CHAN_WIDTH'(i);
      end
    end
  end

  // Lowest latched-mask bit strictly above the channel currently shown.
  always_comb begin
    next_found = 1'b0;
    next_chan  = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (!next_found && mask_q[i] && (i > 32'(chan_q))) begin
        next_found = 1'b1;
        next_chan  = CHAN_WIDTH'(i);
      end
    end
  end

  // Counters hold remaining cycles minus one, so a dwell of 0 behaves as 1.
  assign dwell_load_in = (scan_dwell == '0) ? '0 : scan_dwell - DWELL_WIDTH'(1);
  assign dwell_load_q  = (dwell_q == '0) ? '0 : dwell_q - DWELL_WIDTH'(1);

  // The gap is skipped after the final channel of a single pass.
  assign has_next = next_found || cont_q;
  assign step_adv = ((state_q == DWELL) && (dwell_cnt == '0) && !((gap_q != '0) && has_next)) ||
                    ((state_q == GAP) && (gap_cnt == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      enable_q    <= 1'b0;
      select_q    <= '0;
      chan_q      <= '0;
      mask_q      <= '0;
      cont_q      <= 1'b0;
      sel_q       <= '0;
      dwell_q     <= '0;
      gap_q       <= '0;
      dwell_cnt   <= '0;
      gap_cnt     <= '0;
      scan_active <= 1'b0;
      scan_done   <= 1'b0;
      scan_wrap   <= 1'b0;
      scan_error  <= 1'b0;
    end else begin
      scan_done  <= 1'b0;
      scan_wrap  <= 1'b0;
      scan_error <= 1'b0;
      if (state_q == IDLE) begin
        enable_q <= static_enable;
        select_q <= static_select;
        chan_q   <= static_chan;
        if (scan_start && !scan_stop) begin
          mask_q  <= scan_chan_mask;
          cont_q  <= scan_continuous;
          sel_q   <= scan_select;
          dwell_q <= scan_dwell;
          gap_q   <= scan_gap;
          if (scan_chan_mask == '0) begin
            scan_error <= 1'b1;
          end else begin
            state_q     <= DWELL;
            enable_q    <= 1'b1;
            select_q    <= scan_select;
            chan_q      <= first_start;
            dwell_cnt   <= dwell_load_in;
            scan_active <= 1'b1;
          end
        end
      end else if (scan_stop) begin
        state_q     <= IDLE;
        enable_q    <= static_enable;
        select_q    <= static_select;
        chan_q      <= static_chan;
        scan_active <= 1'b0;
      end else if (step_adv) begin
        if (has_next) begin
          state_q   <= DWELL;
          enable_q  <= 1'b1;
          select_q  <= sel_q;
          chan_q    <= next_found ? next_chan : first_q;
          dwell_cnt <= dwell_load_q;
          scan_wrap <= !next_found;
        end else begin
          state_q     <= IDLE;
          enable_q    <= static_enable;
          select_q    <= static_select;
          chan_q      <= static_chan;
          scan_active <= 1'b0;
          scan_done   <= 1'b1;
        end
      end else if (state_q == DWELL) begin
        if (dwell_cnt != '0) begin
          dwell_cnt <= dwell_cnt - DWELL_WIDTH'(1);
        end else begin
          state_q  <= GAP;
          enable_q <= 1'b0;
          gap_cnt  <= gap_q - 4'd1;
        end
      end else begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_digital_monitor_sequencer.sv
// Directed-vector bench for digital_monitor_sequencer.
// Observed vector = {enable, select, chan, scan_active, scan_done, scan_wrap, scan_error}.
module tb_digital_monitor_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        static_enable;
  logic [3:0]  static_select;
  logic [5:0]  static_chan;
  logic        scan_start;
  logic        scan_stop;
  logic        scan_continuous;
  logic [3:0]  scan_select;
  logic [63:0] scan_chan_mask;
  logic [15:0] scan_dwell;
  logic [3:0]  scan_gap;
  logic        scan_active;
  logic        scan_done;
  logic        scan_wrap;
  logic        scan_error;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  digital_monitor_sequencer_if #(.CHAN_WIDTH(6)) mon ();

  digital_monitor_sequencer #(
    .NUM_CHANNELS(64),
    .CHAN_WIDTH(6),
    .DWELL_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .static_enable(static_enable),
    .static_select(static_select),
    .static_chan(static_chan),
    .scan_start(scan_start),
    .scan_stop(scan_stop),
    .scan_continuous(scan_continuous),
    .scan_select(scan_select),
    .scan_chan_mask(scan_chan_mask),
    .scan_dwell(scan_dwell),
    .scan_gap(scan_gap),
    .mon(mon),
    .scan_active(scan_active),
    .scan_done(scan_done),
    .scan_wrap(scan_wrap),
    .scan_error(scan_error)
  );

  always #5 clk = ~clk;

  wire [14:0] obs = {mon.digital_monitor_enable, mon.digital_monitor_select,
                     mon.digital_monitor_chan, scan_active, scan_done, scan_wrap, scan_error};

  // Static outputs used by every scan scenario: enable 0, select A, chan 9.
  localparam logic [14:0] STATIC_IDLE = {1'b0, 4'hA, 6'd9, 4'b0000};

  task automatic test_reset;
    reset = 1'b1;
    static_enable = 1'b1; static_select = 4'hF; static_chan = 6'd33;
    scan_start = 1'b0; scan_stop = 1'b0; scan_continuous = 1'b0;
    scan_select = '0; scan_chan_mask = '0; scan_dwell = '0; scan_gap = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (obs !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", obs, 15'h0);
    end
    reset = 1'b0;
  endtask

  task automatic test_static;
    static_enable = 1'b1; static_select = 4'b0101; static_chan = 6'd17;
    #1;
    vectors++;
    if (obs !== 15'h0) begin
      miscompares++;
      $display("FAIL static_latency_pre: got %h expected %h", obs, 15'h0);
    end
    @(negedge clk);
    vectors++;
    if (obs !== {1'b1, 4'b0101, 6'd17, 4'b0000}) begin
      miscompares++;
      $display("FAIL static_pass: got %h expected %h", obs, {1'b1, 4'b0101, 6'd17, 4'b0000});
    end
    static_enable = 1'b0; static_select = 4'hA; static_chan = 6'd9;
    @(negedge clk);
    vectors++;
    if (obs !== STATIC_IDLE) begin
      miscompares++;
      $display("FAIL static_change: got %h expected %h", obs, STATIC_IDLE);
    end
  endtask

  task automatic test_single_pass;
    logic [5:0]  chs [3] = '{6'd0, 6'd3, 6'd5};
    logic [14:0] exp;
    scan_chan_mask = 64'h29; scan_dwell = 16'd3; scan_gap = 4'd2;
    scan_continuous = 1'b0; scan_select = 4'h7; scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    scan_chan_mask = '1; scan_dwell = 16'd1; scan_gap = 4'd0; scan_select = 4'h3;
    for (int k = 0; k <= 14; k++) begin
      if (k < 13)
        exp = {((k % 5) < 3), 4'h7, chs[k / 5], 4'b1000};
      else if (k == 13)
        exp = {1'b0, 4'hA, 6'd9, 4'b0100};
      else
        exp = STATIC_IDLE;
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL single_pass[%0d]: got %h expected %h", k, obs, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_continuous;
    logic [5:0]  chs [3] = '{6'd0, 6'd3, 6'd5};
    logic [14:0] exp;
    int r;
    scan_chan_mask = 64'h29; scan_dwell = 16'd3; scan_gap = 4'd2;
    scan_continuous = 1'b1; scan_select = 4'h7; scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    for (int k = 0; k < 45; k++) begin
      r = k % 15;
      exp = {((r % 5) < 3), 4'h7, chs[r / 5], 1'b1, 1'b0, (k >= 15 && r == 0), 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL continuous[%0d]: got %h expected %h", k, obs, exp);
      end
      // A start (with an empty mask) while active must be ignored.
      scan_start = (k == 7);
      if (k == 7) scan_chan_mask = '0;
      scan_stop = (k == 44);
      @(negedge clk);
    end
    scan_stop = 1'b0;
    vectors++;
    if (obs !== STATIC_IDLE) begin
      miscompares++;
      $display("FAIL continuous_stop: got %h expected %h", obs, STATIC_IDLE);
    end
  endtask

  task automatic test_single_chan_wrap;
    logic [14:0] exp;
    scan_chan_mask = 64'h1 << 10; scan_dwell = 16'd2; scan_gap = 4'd1;
    scan_continuous = 1'b1; scan_select = 4'h2; scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      exp = {((k % 3) < 2), 4'h2, 6'd10, 1'b1, 1'b0, (k >= 3 && (k % 3) == 0), 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL single_chan_wrap[%0d]: got %h expected %h", k, obs, exp);
      end
      scan_stop = (k == 8);
      @(negedge clk);
    end
    scan_stop = 1'b0;
    vectors++;
    if (obs !== STATIC_IDLE) begin
      miscompares++;
      $display("FAIL single_chan_stop: got %h expected %h", obs, STATIC_IDLE);
    end
  endtask

  task automatic test_zero_mask;
    scan_chan_mask = '0; scan_dwell = 16'd3; scan_gap = 4'd0;
    scan_continuous = 1'b0; scan_select = 4'h7; scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    vectors++;
    if (obs !== {1'b0, 4'hA, 6'd9, 4'b0001}) begin
      miscompares++;
      $display("FAIL zero_mask_error: got %h expected %h", obs, {1'b0, 4'hA, 6'd9, 4'b0001});
    end
    @(negedge clk);
    vectors++;
    if (obs !== STATIC_IDLE) begin
      miscompares++;
      $display("FAIL zero_mask_after: got %h expected %h", obs, STATIC_IDLE);
    end
  endtask

  task automatic test_stop;
    logic [14:0] exp;
    scan_chan_mask = 64'h29; scan_dwell = 16'd5; scan_gap = 4'd0;
    scan_continuous = 1'b0; scan_select = 4'h7; scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs !== {1'b1, 4'h7, 6'd0, 4'b1000}) begin
        miscompares++;
        $display("FAIL stop_dwell[%0d]: got %h expected %h", k, obs, {1'b1, 4'h7, 6'd0, 4'b1000});
      end
      scan_stop = (k == 1);
      @(negedge clk);
    end
    scan_stop = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs !== STATIC_IDLE) begin
        miscompares++;
        $display("FAIL stop_idle[%0d]: got %h expected %h", k, obs, STATIC_IDLE);
      end
      scan_start = (k == 1);
      @(negedge clk);
    end
    scan_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp = {1'b1, 4'h7, (k < 5) ? 6'd0 : 6'd3, 4'b1000};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL stop_restart[%0d]: got %h expected %h", k, obs, exp);
      end
      scan_stop = (k == 5);
      @(negedge clk);
    end
    scan_stop = 1'b0;
    vectors++;
    if (obs !== STATIC_IDLE) begin
      miscompares++;
      $display("FAIL stop_restart_end: got %h expected %h", obs, STATIC_IDLE);
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0]  chs [3] = '{6'd0, 6'd62, 6'd63};
    logic [14:0] exp;
    scan_chan_mask = 64'hC000_0000_0000_0001; scan_dwell = 16'd0; scan_gap = 4'd0;
    scan_continuous = 1'b0; scan_select = 4'h7; scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 3)
        exp = {1'b1, 4'h7, chs[k], 4'b1000};
      else if (k == 3)
        exp = {1'b0, 4'hA, 6'd9, 4'b0100};
      else
        exp = STATIC_IDLE;
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", k, obs, exp);
      end
      @(negedge clk);
    end
    scan_start = 1'b1; scan_stop = 1'b1;
    @(negedge clk);
    scan_start = 1'b0; scan_stop = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs !== STATIC_IDLE) begin
        miscompares++;
        $display("FAIL start_stop_together[%0d]: got %h expected %h", k, obs, STATIC_IDLE);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_scan;
    scan_chan_mask = 64'h29; scan_dwell = 16'd3; scan_gap = 4'd2;
    scan_continuous = 1'b1; scan_select = 4'h7; scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    vectors++;
    if (obs !== {1'b1, 4'h7, 6'd0, 4'b1000}) begin
      miscompares++;
      $display("FAIL reset_mid_scan_pre: got %h expected %h", obs, {1'b1, 4'h7, 6'd0, 4'b1000});
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (obs !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_mid_scan_async: got %h expected %h", obs, 15'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs !== STATIC_IDLE) begin
      miscompares++;
      $display("FAIL reset_mid_scan_after: got %h expected %h", obs, STATIC_IDLE);
    end
  endtask

  initial begin
    test_reset;
    test_static;
    test_single_pass;
    test_continuous;
    test_single_chan_wrap;
    test_zero_mask;
    test_stop;
    test_back_to_back;
    test_reset_mid_scan;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
